// File: rtl/shift_add_mult32.sv
// shift_add_mult32 -- sequential 32x32 unsigned shift-add multiplier.
//
// One adder32 instance forms the accumulate stage. A start accepted in IDLE
// latches the operands. RUN then performs 32 shift-add iterations, one per
// clock. A one-cycle DONE state presents the 64-bit product.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst    in   1   synchronous, active-high reset
//   start  in   1   multiply request, sampled only in IDLE
//   a      in  32   multiplicand, captured on the accepting edge
//   b      in  32   multiplier, captured on the accepting edge
//   ready  out  1   high in IDLE
//   busy   out  1   high in RUN
//   done   out  1   one-cycle pulse; p valid from this cycle
//   p      out 64   product, held until the next completion

module adder32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_ci,
  output logic [31:0] o_s,
  output logic        o_co
);
  assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_ci};
endmodule

// state  | meaning
// IDLE   | waiting for start; ready=1
// RUN    | one shift-add iteration per edge, 32 in total; busy=1
// DONE   | product valid, done=1 for one cycle
module shift_add_mult32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [63:0] p
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_m;
  logic [31:0] r_a;
  logic [31:0] r_q;
  logic [5:0]  r_cnt;
  logic [63:0] r_p;

  logic [31:0] w_addend;
  logic [31:0] w_sum;
  logic        w_co;
  logic        w_last;

  assign w_addend = r_q[0] ? r_m : 32'd0;
  assign w_last   = (r_cnt == 6'd31);

  adder32 u_adder32 (
    .i_a  (r_a),
    .i_b  (w_addend),
    .i_ci (1'b0),
    .o_s  (w_sum),
    .o_co (w_co)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The carry out of the adder becomes the new A[31] on the right shift.
  // The LSB of the sum moves into the top of Q.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m   <= '0;
      r_a   <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_p   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m   <= a;
            r_q   <= b;
            r_a   <= '0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_a   <= {w_co, w_sum[31:1]};
          r_q   <= {w_sum[0], r_q[31:1]};
          r_cnt <= r_cnt + 6'd1;
          if (w_last) r_p <= {w_co, w_sum[31:1], w_sum[0], r_q[31:1]};
        end
        default: ;
      endcase
    end
  end

  assign ready = (r_state == S_IDLE);
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign p     = r_p;

endmodule

// File: tb/tb_shift_add_mult32.sv
module tb_shift_add_mult32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready, busy, done;
  logic [63:0] p;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  int          iss_q[$];
  int          cyc = 0;
  int          busy_n = 0;
  int          n_acc = 0;
  logic [63:0] model_p = '0;
  logic        mon_en = 1'b0;
  logic        prev_done = 1'b0;

  shift_add_mult32 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Acceptance tracking at the active edge, using pre-edge values.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      iss_q.delete();
      model_p = '0;
      busy_n  = 0;
    end else if (ready && start) begin
      exp_q.push_back(64'(a) * 64'(b));
      iss_q.push_back(cyc - 1);
      n_acc++;
    end
  end

  // Output checks away from the active edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (busy) busy_n++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          logic [63:0] e;
          int          iss;
          e   = exp_q.pop_front();
          iss = iss_q.pop_front();
          chk("product", p, e);
          chk("latency", 64'(cyc - iss), 64'd33);
          chk("busy_len", 64'(busy_n), 64'd32);
          model_p = e;
        end
        busy_n = 0;
        chk("done_width", {63'd0, prev_done}, 64'd0);
      end else begin
        chk("p_hold", p, model_p);
      end
      prev_done = done;
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", {63'd0, (t >= 100)}, 64'd0);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", {63'd0, (t >= 100)}, 64'd0);
  endtask

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v);
    wait_ready();
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int acc0;
    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_busy",  {63'd0, busy},  64'd0);
    chk("rst_done",  {63'd0, done},  64'd0);
    chk("rst_p",     p,              64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Basic and carry cases
    do_op(32'd3, 32'd5);
    chk("basic_3x5", p, 64'h0000_0000_0000_000F);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("ones", p, 64'hFFFF_FFFE_0000_0001);
    do_op(32'h8000_0000, 32'd2);
    chk("msb_x2", p, 64'h0000_0001_0000_0000);
    do_op(32'h1234_5678, 32'd0);
    chk("zero_b", p, 64'd0);
    do_op(32'd0, 32'hDEAD_BEEF);
    chk("zero_a", p, 64'd0);

    // Protocol: starts during RUN and DONE ignored, next IDLE start accepted
    wait_ready();
    a = 32'd3; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 32'd7; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("proto_done_seen", {63'd0, done}, 64'd1);
    chk("proto_p15", p, 64'd15);
    a = 32'd7; b = 32'd7; start = 1'b1;
    @(negedge clk);
    chk("proto_idle_ready", {63'd0, ready}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    chk("proto_p49", p, 64'd49);

    // Reset mid-operation
    wait_ready();
    a = 32'h0000_FFFF; b = 32'h0000_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", {63'd0, ready}, 64'd1);
    chk("abort_done",  {63'd0, done},  64'd0);
    chk("abort_p",     p,              64'd0);
    repeat (40) @(negedge clk);
    do_op(32'h0000_FFFF, 32'h0000_FFFF);
    chk("ffff_sq", p, 64'h0000_0000_FFFE_0001);

    // Start held high: accepted at E0 and again 34 edges later
    wait_ready();
    acc0 = n_acc;
    a = 32'd9; b = 32'd11; start = 1'b1;
    repeat (40) @(negedge clk);
    start = 1'b0;
    wait_drain();
    chk("held_start_accepts", 64'(n_acc - acc0), 64'd2);
    chk("held_start_p", p, 64'd99);

    // Random operands
    for (int i = 0; i < 1000; i++) begin
      do_op($urandom(), $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
